// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: stores received characters with first-word fall-through
// read data, a sticky overrun flag, hysteretic RTS flow control and an
// optional fill-level interrupt enabled by the macro UART_RX_FIFO_THRESH_EN.
//
// Handshake: a write happens on rx_done_i when there is room, or when the
// FIFO is full but a read is accepted in the same cycle. A read happens on
// rd_en_i when the FIFO is not empty. rd_data_o always shows the head entry,
// or 0 when empty. The RTS machine has exactly two states, so rts_n_o is the
// state register itself and doubles as the visible state.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_done_i,
  input  logic [31:0]               rx_data_i,
  input  logic                      rd_en_i,
  input  logic                      flush_i,
  input  logic                      clr_overrun_i,
  input  logic [$clog2(DEPTH):0]    thresh_i,
  output logic [DATA_WIDTH-1:0]     rd_data_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic                      overrun_o,
  output logic                      rts_n_o,
  output logic                      thresh_irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] STOP_LVL   = CW'(DEPTH - 2);
  localparam logic [CW-1:0] RESUME_LVL = CW'(DEPTH / 2);

  typedef enum logic {
    RTS_ASSERTED = 1'b0,
    RTS_STOPPED  = 1'b1
  } rts_state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overrun_q, overrun_d;
  rts_state_e            rts_state_q, rts_state_d;
  logic                  full, empty;
  logic                  rd_ok, wr_ok, drop;

  // Upper character bits are not stored.
  logic unused_rx;
  assign unused_rx = ^rx_data_i;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign rd_ok = rd_en_i && !empty;
  assign wr_ok = rx_done_i && (!full || rd_ok);
  assign drop  = rx_done_i && full && !rd_ok;

  // Next-state for pointers, count and overrun; flush overrides read/write.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_ok && !rd_ok) count_d = count_q + CW'(1);
      else if (rd_ok && !wr_ok) count_d = count_q - CW'(1);
    end
    if (drop && !flush_i) overrun_d = 1'b1;
    else if (clr_overrun_i) overrun_d = 1'b0;
  end

  // RTS hysteresis: stop near full, resume once drained to half.
  always_comb begin
    rts_state_d = rts_state_q;
    case (rts_state_q)
      RTS_ASSERTED: if (count_d >= STOP_LVL)   rts_state_d = RTS_STOPPED;
      RTS_STOPPED:  if (count_d <= RESUME_LVL) rts_state_d = RTS_ASSERTED;
      default:      rts_state_d = RTS_ASSERTED;
    endcase
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      rts_state_q <= RTS_ASSERTED;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      rts_state_q <= rts_state_d;
    end
  end

  // Character storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush_i) mem_q[wr_ptr_q] <= rx_data_i[DATA_WIDTH-1:0];
  end

`ifdef UART_RX_FIFO_THRESH_EN
  logic thresh_irq_q;

  // Fill-level interrupt tracks the count being loaded this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) thresh_irq_q <= 1'b0;
    else     thresh_irq_q <= (count_d >= thresh_i) && (thresh_i != '0);
  end

  assign thresh_irq_o = thresh_irq_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh_i;
  assign thresh_irq_o  = 1'b0;
`endif

  assign rd_data_o = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign empty_o   = empty;
  assign full_o    = full;
  assign overrun_o = overrun_q;
  assign rts_n_o   = (rts_state_q == RTS_STOPPED);

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: number of stored bits per received character.
REQ-002 Parameter DEPTH, default 16: number of FIFO entries; SHALL be a power of two and at least 4.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port rx_done_i, input, 1 bit: one-cycle pulse from the receiver marking a completed character.
REQ-006 Port rx_data_i, input, 32 bits: received character; only bits [DATA_WIDTH-1:0] are stored.
REQ-007 Port rd_en_i, input, 1 bit: pop request from the register block.
REQ-008 Port flush_i, input, 1 bit: synchronous FIFO clear.
REQ-009 Port clr_overrun_i, input, 1 bit: clears the overrun flag.
REQ-010 Port thresh_i, input, $clog2(DEPTH)+1 bits: interrupt fill level.
REQ-011 Port rd_data_o, output, DATA_WIDTH bits: head entry (first-word fall-through).
REQ-012 Port count_o, output, $clog2(DEPTH)+1 bits: current number of stored entries.
REQ-013 Port empty_o, output, 1 bit: high when count_o equals 0.
REQ-014 Port full_o, output, 1 bit: high when count_o equals DEPTH.
REQ-015 Port overrun_o, output, 1 bit: sticky flag set when a character is dropped.
REQ-016 Port rts_n_o, output, 1 bit: active-low ready-to-send flow control toward the peripheral.
REQ-017 Port thresh_irq_o, output, 1 bit: registered fill-level interrupt.

Function
REQ-018 A write SHALL occur when rx_done_i=1 and either full_o=0, or full_o=1 with a same-cycle valid read; the write stores rx_data_i[DATA_WIDTH-1:0] at the write pointer.
REQ-019 A read SHALL occur when rd_en_i=1 and empty_o=0; it advances the read pointer, and rd_data_o shows the new head one cycle later.
REQ-020 rd_en_i while empty SHALL be ignored, with no pointer change and no flag.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 count_o SHALL update in the cycle after the request: +1 for write only, -1 for read only, unchanged for simultaneous read and write.
REQ-023 When empty_o=1, simultaneous rx_done_i and rd_en_i SHALL accept the write and ignore the read.
REQ-024 When full_o=1 and rx_done_i=1 with no valid read, the character SHALL be dropped, overrun_o SHALL be set the next cycle, and FIFO contents SHALL be unchanged.
REQ-025 overrun_o SHALL remain set until clr_overrun_i=1; if set and clear coincide, set wins.
REQ-026 rd_data_o SHALL be 0 whenever empty_o=1.
REQ-027 flush_i=1 SHALL zero both pointers and count_o next cycle, take priority over a same-cycle read or write, and leave overrun_o unchanged.
REQ-028 rts_n_o SHALL be a two-state registered machine:
  - ASSERTED (rts_n_o=0) moves to STOPPED (rts_n_o=1) when the next count is at least DEPTH-2.
  - STOPPED returns to ASSERTED when the next count is at most DEPTH/2.
REQ-029 All flags SHALL be derived from the registered count, so no combinational path exists from rx_done_i to any output.

Reset
REQ-030 While rst=1, pointers, count_o, overrun_o and thresh_irq_o SHALL be 0, empty_o=1, full_o=0, rts_n_o=0 and rd_data_o=0; storage contents need not be reset.
REQ-031 Asserting rst mid-operation SHALL discard all entries immediately, independent of clk.

Configuration
REQ-032 With macro UART_RX_FIFO_THRESH_EN defined, thresh_irq_o SHALL be registered (count_o >= thresh_i) AND (thresh_i != 0), updated every cycle.
REQ-033 Without UART_RX_FIFO_THRESH_EN, thresh_irq_o SHALL be constant 0, thresh_i SHALL be ignored, and no threshold logic SHALL be synthesized.

Verification
REQ-034 Reset, then write 0x41, 0x42, 0x43, then read 3 times -> rd_data_o is 0x41, 0x42, 0x43 in order, count_o goes 3 to 0, and empty_o=1.
REQ-035 Fill 16 entries, then send a 17th rx_done_i with 0x99 -> full_o=1, overrun_o=1, the 17th write is dropped and head is still the first byte; clr_overrun_i clears overrun_o.
REQ-036 With FIFO full, assert rx_done_i and rd_en_i in the same cycle -> count_o stays 16, overrun_o stays 0, and the new byte is read last.
REQ-037 Fill to 14 -> rts_n_o=1; drain to 9 -> rts_n_o stays 1; drain to 8 -> rts_n_o=0.
REQ-038 With UART_RX_FIFO_THRESH_EN and thresh_i=4: 3 writes -> thresh_irq_o=0; 4th write -> thresh_irq_o=1 the next cycle. Repeat with thresh_i=0 -> thresh_irq_o stays 0.
REQ-039 Apply flush_i with a same-cycle write at count 5 -> count_o=0 and empty_o=1; separately, pulse rst with 7 entries -> all outputs at reset values without waiting for a clk edge.
